reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter_if.sv | 33 +++
 rtl/reg_write_arbiter.sv | 85 ++++++++
 tb/tb_reg_write_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/reg_write_arbiter_if.sv
// Requester-side bus of the shared register write arbiter.
// The master drives requests, the slave (arbiter) returns grant/ack/data.
interface reg_write_arbiter_if #(
  parameter int WID_DATA = 32
);
  logic                    Hold;
  logic [3:0]              Req;
  logic [4*WID_DATA-1:0]   DataIn;
  logic [3:0]              Ack;
  logic [3:0]              Grant;
  logic                    Busy;
  logic [WID_DATA-1:0]     DataOut;

  modport master (
    output Hold,
    output Req,
    output DataIn,
    input  Ack,
    input  Grant,
    input  Busy,
    input  DataOut
  );

  modport slave (
    input  Hold,
    input  Req,
    input  DataIn,
    output Ack,
    output Grant,
    output Busy,
    output DataOut
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for four writers of one shared register.
// Each transaction is IDLE -> WRITE -> ACK, one cycle per state.
module reg_write_arbiter #(
  parameter int                  WID_DATA  = 32,
  parameter logic [WID_DATA-1:0] RST_VALUE = '0
) (
  input  logic                 Clock,
  input  logic                 Reset,
  reg_write_arbiter_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [1:0]          win_q, win_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [WID_DATA-1:0] data_q, data_d;

  logic [1:0] pick;
  logic [1:0] idx;
  logic       found;

  always_comb begin
    pick  = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && bus.Req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (!bus.Hold && found) begin
          win_d   = pick;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        data_d  = bus.DataIn[int'(win_q)*WID_DATA +: WID_DATA];
        state_d = S_ACK;
      end
      S_ACK: begin
        ptr_d   = win_q + 2'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      win_q   <= 2'd0;
      ptr_q   <= 2'd0;
      data_q  <= RST_VALUE;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
    end
  end

  // A reset arriving mid-ACK kills that cycle's pulse.
  assign bus.Ack   = (state_q == S_ACK && Reset) ?
                     (4'b0001 << win_q) : 4'b0000;
  assign bus.Grant = (state_q == S_WRITE) ?
                     (4'b0001 << win_q) : 4'b0000;
  assign bus.Busy    = (state_q == S_WRITE) ||
                       (state_q == S_ACK);
  assign bus.DataOut = data_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: vector table through a scoreboard
// queue, then a hand-driven reset-during-ACK sequence.
module tb_reg_write_arbiter;
  localparam int          W  = 32;
  localparam logic [31:0] RV = 32'h0BAD_F00D;

  localparam logic [127:0] D_A =
    {32'h3, 32'h2, 32'h1, 32'hA5A5_A5A5};
  localparam logic [127:0] D_N =
    {32'h3, 32'h2, 32'h1, 32'h0};
  localparam logic [127:0] D_X =
    {32'h3, 32'h55, 32'h77, 32'h0};

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  reg_write_arbiter_if #(.WID_DATA(W)) bus ();

  reg_write_arbiter #(
    .WID_DATA (W),
    .RST_VALUE(RV)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string        nm;
    logic         rst_n;
    logic         hold;
    logic [3:0]   req;
    logic [127:0] din;
    logic [3:0]   ack;
    logic [3:0]   grant;
    logic         busy;
    logic [31:0]  dout;
  } vec_t;

  typedef struct packed {
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        busy;
    logic [31:0] dout;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic add(input string nm, input logic r,
                     input logic h, input logic [3:0] q,
                     input logic [127:0] d,
                     input logic [3:0] a, input logic [3:0] g,
                     input logic b, input logic [31:0] o);
    vec_t v;
    v.nm = nm; v.rst_n = r; v.hold = h; v.req = q;
    v.din = d; v.ack = a; v.grant = g; v.busy = b;
    v.dout = o;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp)
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    else
      passed++;
  endtask

  initial begin
    bus.Hold   = 1'b0;
    bus.Req    = 4'b0;
    bus.DataIn = D_A;

    // single write of requester 0
    add("rst0",   0,0,4'b0000,D_A,4'b0000,4'b0000,0,RV);
    add("w0",     1,0,4'b0001,D_A,4'b0000,4'b0001,1,RV);
    add("a0",     1,0,4'b0001,D_A,4'b0001,4'b0000,1,32'hA5A5A5A5);
    add("i0",     1,0,4'b0000,D_A,4'b0000,4'b0000,0,32'hA5A5A5A5);
    // all four requesting: rotation
    add("rst1",   0,0,4'b0000,D_N,4'b0000,4'b0000,0,RV);
    add("rr_w0",  1,0,4'b1111,D_N,4'b0000,4'b0001,1,RV);
    add("rr_a0",  1,0,4'b1111,D_N,4'b0001,4'b0000,1,32'h0);
    add("rr_i0",  1,0,4'b1111,D_N,4'b0000,4'b0000,0,32'h0);
    add("rr_w1",  1,0,4'b1111,D_N,4'b0000,4'b0010,1,32'h0);
    add("rr_a1",  1,0,4'b1111,D_N,4'b0010,4'b0000,1,32'h1);
    add("rr_i1",  1,0,4'b1111,D_N,4'b0000,4'b0000,0,32'h1);
    add("rr_w2",  1,0,4'b1111,D_N,4'b0000,4'b0100,1,32'h1);
    add("rr_a2",  1,0,4'b1111,D_N,4'b0100,4'b0000,1,32'h2);
    add("rr_i2",  1,0,4'b1111,D_N,4'b0000,4'b0000,0,32'h2);
    add("rr_w3",  1,0,4'b1111,D_N,4'b0000,4'b1000,1,32'h2);
    add("rr_a3",  1,0,4'b1111,D_N,4'b1000,4'b0000,1,32'h3);
    add("rr_i3",  1,0,4'b1111,D_N,4'b0000,4'b0000,0,32'h3);
    add("rr_w0b", 1,0,4'b1111,D_N,4'b0000,4'b0001,1,32'h3);
    add("rr_a0b", 1,0,4'b1111,D_N,4'b0001,4'b0000,1,32'h0);
    add("rr_end", 1,0,4'b0000,D_N,4'b0000,4'b0000,0,32'h0);
    // hold blocks arbitration
    add("rst2",   0,0,4'b0000,D_N,4'b0000,4'b0000,0,RV);
    for (int i = 0; i < 5; i++)
      add("hold",  1,1,4'b0100,D_N,4'b0000,4'b0000,0,RV);
    add("hold_w", 1,0,4'b0100,D_N,4'b0000,4'b0100,1,RV);
    add("hold_a", 1,0,4'b0100,D_N,4'b0100,4'b0000,1,32'h2);
    add("hold_i", 1,0,4'b0000,D_N,4'b0000,4'b0000,0,32'h2);
    // reset in WRITE of requester 2
    add("rw_w2",  1,0,4'b0100,D_X,4'b0000,4'b0100,1,32'h2);
    add("rw_rst", 0,0,4'b0100,D_X,4'b0000,4'b0000,0,RV);
    add("rw_w2b", 1,0,4'b1100,D_X,4'b0000,4'b0100,1,RV);
    add("rw_a2",  1,0,4'b1100,D_X,4'b0100,4'b0000,1,32'h55);
    add("rw_i",   1,0,4'b0000,D_X,4'b0000,4'b0000,0,32'h55);
    // requester 1 drops Req during WRITE
    add("rst3",   0,0,4'b0000,D_X,4'b0000,4'b0000,0,RV);
    add("dr_w1",  1,0,4'b0010,D_X,4'b0000,4'b0010,1,RV);
    add("dr_a1",  1,0,4'b0000,D_X,4'b0010,4'b0000,1,32'h77);
    add("dr_i",   1,0,4'b0000,D_X,4'b0000,4'b0000,0,32'h77);
    add("dr_p2w", 1,0,4'b0110,D_X,4'b0000,4'b0100,1,32'h77);
    add("dr_p2a", 1,0,4'b0000,D_X,4'b0100,4'b0000,1,32'h55);
    add("dr_p2i", 1,0,4'b0000,D_X,4'b0000,4'b0000,0,32'h55);
    // only requester 3, then pointer wrap
    add("rst4",   0,0,4'b0000,D_X,4'b0000,4'b0000,0,RV);
    add("r3_w",   1,0,4'b1000,D_X,4'b0000,4'b1000,1,RV);
    add("r3_a",   1,0,4'b1000,D_X,4'b1000,4'b0000,1,32'h3);
    add("r3_i",   1,0,4'b0000,D_X,4'b0000,4'b0000,0,32'h3);
    add("wrap_w", 1,0,4'b1001,D_X,4'b0000,4'b0001,1,32'h3);
    add("wrap_a", 1,0,4'b0000,D_X,4'b0001,4'b0000,1,32'h0);
    add("wrap_i", 1,0,4'b0000,D_X,4'b0000,4'b0000,0,32'h0);
    // hold and noise during an in-flight transaction
    add("hf_w",   1,0,4'b0100,D_X,4'b0000,4'b0100,1,32'h0);
    add("hf_a",   1,1,4'b1111,D_X,4'b0100,4'b0000,1,32'h55);
    add("hf_i0",  1,1,4'b0100,D_X,4'b0000,4'b0000,0,32'h55);
    add("hf_i1",  1,1,4'b0100,D_X,4'b0000,4'b0000,0,32'h55);
    add("hf_w2",  1,0,4'b0100,D_X,4'b0000,4'b0100,1,32'h55);
    add("hf_a2",  1,0,4'b0100,D_X,4'b0100,4'b0000,1,32'h55);
    add("hf_end", 1,0,4'b0000,D_X,4'b0000,4'b0000,0,32'h55);

    foreach (tbl[i]) begin
      exp_t e, g;
      @(negedge Clock);
      Reset      = tbl[i].rst_n;
      bus.Hold   = tbl[i].hold;
      bus.Req    = tbl[i].req;
      bus.DataIn = tbl[i].din;
      sb.push_back('{tbl[i].ack, tbl[i].grant,
                     tbl[i].busy, tbl[i].dout});
      @(posedge Clock);
      #1;
      g = '{bus.Ack, bus.Grant, bus.Busy, bus.DataOut};
      e = sb.pop_front();
      checks++;
      if (g !== e)
        $display("FAIL %s got ack=%b grant=%b busy=%b dout=%h want ack=%b grant=%b busy=%b dout=%h",
                 tbl[i].nm, g.ack, g.grant, g.busy, g.dout,
                 e.ack, e.grant, e.busy, e.dout);
      else
        passed++;
    end

    // reset asserted inside an ACK cycle
    @(negedge Clock);
    Reset = 1'b1; bus.Hold = 1'b0;
    bus.Req = 4'b0010; bus.DataIn = D_X;
    @(posedge Clock); #1;
    chk("ra_grant", 64'(bus.Grant), 64'h2);
    @(negedge Clock);
    bus.Req = 4'b0000;
    @(posedge Clock); #1;
    chk("ra_ack", 64'(bus.Ack), 64'h2);
    Reset = 1'b0;
    #1;
    chk("ra_ack_kill", 64'(bus.Ack), 64'h0);
    chk("ra_dout", 64'(bus.DataOut), 64'h77);
    @(posedge Clock); #1;
    chk("ra_rst_dout", 64'(bus.DataOut), 64'(RV));
    chk("ra_rst_busy", 64'(bus.Busy), 64'h0);
    @(negedge Clock);
    Reset = 1'b1; bus.Req = 4'b0110;
    @(posedge Clock); #1;
    chk("ra_ptr0", 64'(bus.Grant), 64'h2);
    @(negedge Clock);
    bus.Req = 4'b0000;
    @(posedge Clock); #1;
    chk("ra_ack2", 64'(bus.Ack), 64'h2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
